// File: rtl/cnn_stage_sequencer.sv
// Layer sequencer for the quickdraw CNN: launches each stage in order with a one-cycle
// start pulse, waits for its done pulse, and reports timeouts, stray dones and aborts.
module cnn_stage_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int TIMEOUT    = 200000,
    parameter int TIMEOUT_W  = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NUM_STAGES-1:0]         stage_done,
    output logic [NUM_STAGES-1:0]         stage_start,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [1:0]                    err_code,
    output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
    output logic [31:0]                   cycle_count
);
    localparam int SW = $clog2(NUM_STAGES);
    localparam logic [SW-1:0]        LAST_STAGE = SW'(NUM_STAGES - 1);
    localparam logic [TIMEOUT_W-1:0] WD_LIMIT   = TIMEOUT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_SPURIOUS = 2'd2;
    localparam logic [1:0] ERR_ABORT    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t                state, state_nx;
    logic [TIMEOUT_W-1:0]  watchdog, watchdog_nx;
    logic [1:0]            err_code_nx;
    logic [SW-1:0]         cur_stage_nx;
    logic                  run_clear;
    logic [NUM_STAGES-1:0] stage_sel;
    logic                  own_done;
    logic                  stray_done;

    // One-hot of the active stage; used both for the start pulse and done filtering.
    always_comb begin
        stage_sel  = NUM_STAGES'(1) << cur_stage;
        own_done   = |(stage_done & stage_sel);
        stray_done = |(stage_done & ~stage_sel);
    end

    always_comb begin
        state_nx     = state;
        watchdog_nx  = watchdog;
        err_code_nx  = err_code;
        cur_stage_nx = cur_stage;
        run_clear    = 1'b0;
        case (state)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_nx     = S_LAUNCH;
                    cur_stage_nx = '0;
                    err_code_nx  = ERR_NONE;
                    run_clear    = 1'b1;
                end
            end
            S_LAUNCH: begin
                watchdog_nx = '0;
                if (abort) begin
                    state_nx    = S_ERROR;
                    err_code_nx = ERR_ABORT;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                // A correct done wins over any stray bits arriving with it.
                if (abort) begin
                    state_nx    = S_ERROR;
                    err_code_nx = ERR_ABORT;
                end else if (own_done) begin
                    if (cur_stage == LAST_STAGE) begin
                        state_nx = S_FINISH;
                    end else begin
                        cur_stage_nx = cur_stage + 1'b1;
                        state_nx     = S_LAUNCH;
                    end
                end else if (stray_done) begin
                    state_nx    = S_ERROR;
                    err_code_nx = ERR_SPURIOUS;
                end else if (watchdog == WD_LIMIT) begin
                    state_nx    = S_ERROR;
                    err_code_nx = ERR_TIMEOUT;
                end else begin
                    watchdog_nx = watchdog + 1'b1;
                end
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            watchdog  <= '0;
            err_code  <= ERR_NONE;
            cur_stage <= '0;
        end else begin
            state     <= state_nx;
            watchdog  <= watchdog_nx;
            err_code  <= err_code_nx;
            cur_stage <= cur_stage_nx;
        end
    end

    // Counts LAUNCH and WAIT cycles only, saturating rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (run_clear) begin
            cycle_count <= '0;
        end else if ((state == S_LAUNCH || state == S_WAIT) && cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    always_comb begin
        stage_start = (state == S_LAUNCH) ? stage_sel : '0;
        busy        = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_FINISH);
        done        = (state == S_FINISH);
        error       = (state == S_ERROR);
    end
endmodule
